// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
//
// Bundles every signal of the fetch sequencer apart from clock and reset.
// This covers the hazard-unit stall, the imem handshake, halt, and the three
// EX-stage redirect sources. It also carries the IF/ID valid, flush and
// halted status back to the pipeline.
//
// Modports:
//   master : the fetch sequencer's view. It receives stall/ihit/halt and the
//            redirect inputs, and drives imemREN, imemaddr, if_valid, flush
//            and halted.
//   slave  : the surrounding core's view, with the directions reversed.
// -----------------------------------------------------------------------------
interface fetch_sequencer_if #(
    parameter int AW = 32
);
    // Hazard unit / imem handshake / retire
    logic          stall;
    logic          ihit;
    logic          halt;

    // EX-stage redirect sources
    logic          br_taken;
    logic [AW-1:0] br_target;
    logic          jump;
    logic [AW-1:0] jump_target;
    logic          jr;
    logic [AW-1:0] jr_target;

    // Fetch outputs
    logic          imemREN;
    logic [AW-1:0] imemaddr;
    logic          if_valid;
    logic          flush;
    logic          halted;

    modport master (
        input  stall, ihit, halt,
        input  br_taken, br_target, jump, jump_target, jr, jr_target,
        output imemREN, imemaddr, if_valid, flush, halted
    );

    modport slave (
        output stall, ihit, halt,
        output br_taken, br_target, jump, jump_target, jr, jr_target,
        input  imemREN, imemaddr, if_valid, flush, halted
    );
endinterface

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Per-core instruction-fetch controller. This block owns the fetch PC and
// drives the imem read request. It advances the PC on completed,
// non-stalled fetches. It also takes redirects from EX (jr > jump > taken
// branch) and flushes IF/ID and ID/EX when a redirect is accepted.
//
// A redirect that arrives while an imem access is still outstanding cannot
// move the address without breaking the bus rule. The rule is that the
// address must hold while imemREN is high and ihit is low. Such a redirect is
// parked in pend_pc, and the in-flight word is discarded when it returns.
//
// Ports:
//   clk   : clock
//   nRst  : asynchronous active-low reset
//   bus   : fetch_sequencer_if.master
//           in : stall, ihit, halt, br_taken/br_target, jump/jump_target,
//                jr/jr_target
//           out: imemREN, imemaddr (the PC), if_valid, flush, halted
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int          AW      = 32,
    parameter logic [AW-1:0] PC_INIT = '0
) (
    input  logic               clk,
    input  logic               nRst,
    fetch_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,  // normal fetching
        RWAIT  = 2'd1,  // redirect parked behind an outstanding access
        HALTED = 2'd2   // terminal until reset
    } state_e;

    state_e        state_q,   state_d;
    logic [AW-1:0] pc_q,      pc_d;
    logic [AW-1:0] pend_pc_q, pend_pc_d;

    logic          rd_valid;
    logic [AW-1:0] rd_raw;
    logic [AW-1:0] rd_target;
    logic          if_valid_c;
    logic          flush_c;

    // -------------------------------------------------------------------------
    // Redirect selection: jr beats jump, and jump beats a taken branch.
    // Fetch addresses are word aligned, so the low two bits are cleared.
    // -------------------------------------------------------------------------
    always_comb begin
        rd_valid = bus.jr | bus.jump | bus.br_taken;
        if (bus.jr)
            rd_raw = bus.jr_target;
        else if (bus.jump)
            rd_raw = bus.jump_target;
        else
            rd_raw = bus.br_target;
        rd_target = rd_raw & ~AW'(3);
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first. This means no path
    // can leave a signal unassigned, so no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        if_valid_c = 1'b0;
        flush_c    = 1'b0;

        unique case (state_q)
            FETCH: begin
                if (bus.halt) begin
                    // Halt outranks redirects. The in-flight access must finish
                    // first. The word it returns is never handed to IF/ID.
                    if (bus.ihit)
                        state_d = HALTED;
                end else if (rd_valid) begin
                    // A redirect overrides stall. The word returned this cycle
                    // is on the wrong path, so if_valid stays low.
                    flush_c = 1'b1;
                    if (bus.ihit) begin
                        pc_d = rd_target;
                    end else begin
                        pend_pc_d = rd_target;
                        state_d   = RWAIT;
                    end
                end else if (bus.ihit && !bus.stall) begin
                    pc_d       = pc_q + AW'(4);  // wraps modulo 2^AW
                    if_valid_c = 1'b1;
                end
                // With ihit and stall both set, the PC holds. The same word is
                // fetched again next cycle.
            end

            RWAIT: begin
                if (bus.halt) begin
                    // The parked redirect is abandoned. pend_pc is simply
                    // never consumed.
                    if (bus.ihit)
                        state_d = HALTED;
                end else if (rd_valid) begin
                    // A newer redirect replaces the parked one.
                    flush_c = 1'b1;
                    if (bus.ihit) begin
                        pc_d    = rd_target;
                        state_d = FETCH;
                    end else begin
                        pend_pc_d = rd_target;
                    end
                end else if (bus.ihit) begin
                    // The stale word returns and is dropped. Then fetching
                    // moves to the parked target.
                    pc_d    = pend_pc_q;
                    state_d = FETCH;
                end
            end

            HALTED: begin
                // Frozen: every input is ignored.
            end

            default: begin
                state_d = HALTED;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments. Every flop then
    // samples its pre-edge value, whatever order the statements appear in.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= FETCH;
            pc_q      <= PC_INIT;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. The combinational strobes are qualified by nRst so that no
    // request, valid or flush escapes while reset is held. The state register
    // alone would already read FETCH during reset.
    // -------------------------------------------------------------------------
    assign bus.imemaddr = pc_q;
    assign bus.imemREN  = nRst && (state_q != HALTED);
    assign bus.if_valid = nRst && if_valid_c;
    assign bus.flush    = nRst && flush_c;
    assign bus.halted   = (state_q == HALTED);

    // -------------------------------------------------------------------------
    // Protocol invariants
    // -------------------------------------------------------------------------
    // The address must not move under an outstanding request.
    a_addr_stable : assert property (@(posedge clk) disable iff (!nRst)
        (bus.imemREN && !bus.ihit) |=> $stable(bus.imemaddr));

    // A squashed cycle never delivers a word.
    a_valid_flush : assert property (@(posedge clk) disable iff (!nRst)
        !(bus.if_valid && bus.flush));

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed walk through the fetch sequencer's main scenarios, followed by a
// randomized phase. Every cycle's outputs are compared against a small
// behavioural model. The model tracks the PC, any parked redirect and the
// halted condition.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam int            AW      = 32;
    localparam logic [AW-1:0] PC_INIT = 32'h0000_0000;

    logic clk  = 1'b0;
    logic nRst = 1'b0;
    always #5 clk = ~clk;

    fetch_sequencer_if #(.AW(AW)) bus ();

    fetch_sequencer #(.AW(AW), .PC_INIT(PC_INIT)) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_pend;
    bit            m_pending;
    bit            m_halted;

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = PC_INIT;
        m_pend    = '0;
        m_pending = 1'b0;
        m_halted  = 1'b0;
    endtask

    function automatic logic [AW-1:0] pick_target();
        logic [AW-1:0] t;
        t = bus.jr ? bus.jr_target : (bus.jump ? bus.jump_target : bus.br_target);
        return {t[AW-1:2], 2'b00};
    endfunction

    // Compare the combinational view of the current cycle against the model.
    task automatic check_outputs(input string tag);
        bit redirect;
        bit exp_flush;
        bit exp_valid;
        redirect  = bus.jr || bus.jump || bus.br_taken;
        exp_flush = !m_halted && !bus.halt && redirect;
        exp_valid = !m_halted && !bus.halt && !redirect && !m_pending && bus.ihit && !bus.stall;
        chk({tag, ".imemaddr"}, bus.imemaddr, m_pc);
        chk({tag, ".imemREN"},  AW'(bus.imemREN),  AW'(!m_halted));
        chk({tag, ".halted"},   AW'(bus.halted),   AW'(m_halted));
        chk({tag, ".flush"},    AW'(bus.flush),    AW'(exp_flush));
        chk({tag, ".if_valid"}, AW'(bus.if_valid), AW'(exp_valid));
    endtask

    // Apply the inputs sampled at the rising edge to the model.
    task automatic model_advance();
        if (m_halted) return;
        if (bus.halt) begin
            if (bus.ihit) m_halted = 1'b1;
        end else if (bus.jr || bus.jump || bus.br_taken) begin
            if (bus.ihit) begin
                m_pc      = pick_target();
                m_pending = 1'b0;
            end else begin
                m_pend    = pick_target();
                m_pending = 1'b1;
            end
        end else if (bus.ihit) begin
            if (m_pending) begin
                m_pc      = m_pend;
                m_pending = 1'b0;
            end else if (!bus.stall) begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic drive(input bit st, input bit ih, input bit hl,
                         input bit br, input logic [AW-1:0] brt,
                         input bit jp, input logic [AW-1:0] jpt,
                         input bit jrr, input logic [AW-1:0] jrt);
        bus.stall       = st;
        bus.ihit        = ih;
        bus.halt        = hl;
        bus.br_taken    = br;
        bus.br_target   = brt;
        bus.jump        = jp;
        bus.jump_target = jpt;
        bus.jr          = jrr;
        bus.jr_target   = jrt;
    endtask

    // One clock: drive just after the falling edge, check 1 time unit later,
    // let the rising edge happen, update the model, and return at the next
    // falling edge.
    task automatic step(input string tag, input bit st, input bit ih, input bit hl,
                        input bit br, input logic [AW-1:0] brt,
                        input bit jp, input logic [AW-1:0] jpt,
                        input bit jrr, input logic [AW-1:0] jrt);
        drive(st, ih, hl, br, brt, jp, jpt, jrr, jrt);
        #1;
        check_outputs(tag);
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    task automatic plain(input string tag, input bit st, input bit ih);
        step(tag, st, ih, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic jump_to(input string tag, input bit ih, input logic [AW-1:0] t);
        step(tag, 1'b0, ih, 1'b0, 1'b0, '0, 1'b1, t, 1'b0, '0);
    endtask

    initial begin
        // ---------------- reset -----------------
        model_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        #3;
        chk("rst.imemREN",  AW'(bus.imemREN),  '0);
        chk("rst.imemaddr", bus.imemaddr,      PC_INIT);
        chk("rst.if_valid", AW'(bus.if_valid), '0);
        chk("rst.flush",    AW'(bus.flush),    '0);
        chk("rst.halted",   AW'(bus.halted),   '0);
        @(negedge clk);
        @(negedge clk);
        nRst = 1'b1;

        // ---------------- streaming: 0,4,8,C ----------------
        for (int i = 0; i < 4; i++) plain("stream", 1'b0, 1'b1);
        chk("stream.end", bus.imemaddr, 32'h10);

        // ---------------- branch at 0x10, then jr vs jump ----------------
        step("br", 1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 1'b0, '0, 1'b0, '0);
        chk("br.addr", bus.imemaddr, 32'h40);
        step("jr_pri", 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 32'h200, 1'b1, 32'h81);
        chk("jr_pri.addr", bus.imemaddr, 32'h80);

        // ---------------- redirect behind an outstanding access -----------
        jump_to("to20", 1'b1, 32'h20);
        jump_to("rwait", 1'b0, 32'h100);
        chk("rwait.hold", bus.imemaddr, 32'h20);
        plain("rwait.w", 1'b0, 1'b0);
        plain("rwait.hit", 1'b0, 1'b1);
        chk("rwait.addr", bus.imemaddr, 32'h100);

        // ---------------- slow memory: 2 wait cycles per access ----------
        for (int a = 0; a < 2; a++) begin
            plain("slow.w0", 1'b0, 1'b0);
            plain("slow.w1", 1'b0, 1'b0);
            plain("slow.hit", 1'b0, 1'b1);
        end
        chk("slow.addr", bus.imemaddr, 32'h108);

        // ---------------- stall at 0x30 ----------------
        jump_to("to30", 1'b1, 32'h30);
        for (int i = 0; i < 3; i++) plain("stall", 1'b1, 1'b1);
        chk("stall.hold", bus.imemaddr, 32'h30);
        plain("stall.rel", 1'b0, 1'b1);
        chk("stall.addr", bus.imemaddr, 32'h34);

        // ---------------- wrap at top of address space ----------------
        jump_to("toTop", 1'b1, 32'hFFFF_FFFC);
        plain("wrap", 1'b0, 1'b1);
        chk("wrap.addr", bus.imemaddr, 32'h0);

        // ---------------- reset while a redirect is parked ----------------
        jump_to("to200", 1'b1, 32'h200);
        jump_to("rst_rw", 1'b0, 32'h300);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h400, 1'b0, '0, 1'b0, '0);
        #2 nRst = 1'b0;
        #1;
        model_reset();
        chk("rst_rw.imemaddr", bus.imemaddr,      PC_INIT);
        chk("rst_rw.flush",    AW'(bus.flush),    '0);
        chk("rst_rw.imemREN",  AW'(bus.imemREN),  '0);
        @(negedge clk);
        nRst = 1'b1;
        plain("rst_rw.hit", 1'b0, 1'b1);
        chk("rst_rw.next", bus.imemaddr, PC_INIT + 32'd4);

        // ---------------- randomized traffic (no halt) ----------------
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) < 6,
                 1'b0,
                 $urandom_range(0, 5) == 0, $urandom,
                 $urandom_range(0, 7) == 0, $urandom,
                 $urandom_range(0, 9) == 0, $urandom);
        end

        // ---------------- halt at 0x50 ----------------
        jump_to("to50", 1'b1, 32'h50);
        step("halt.w", 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        step("halt.hit", 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        chk("halt.halted", AW'(bus.halted),  32'h1);
        chk("halt.ren",    AW'(bus.imemREN), 32'h0);
        step("halt.br", 1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 1'b0, '0, 1'b0, '0);
        chk("halt.addr", bus.imemaddr, 32'h50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
